parking_lot_controller: RTL and testbench
=========================================

# parking_lot_controller

Parametrised successor to the single-gate car parking controller. It keeps the entry flow (sense, password, open or refuse) and adds:
- configurable capacity and password width;
- retry limit with timed lockout;
- password timeout;
- an independent exit path that runs concurrently with entry.

It sits between the gate sensors/keypad and the gate actuators and status lamps.

## Interface
Parameters:
- CAPACITY, 8, number of spaces (>=1)
- PW_WIDTH, 4, password width in bits
- PASSWORD, 4'b0101, correct code (PW_WIDTH bits)
- MAX_TRIES, 3, wrong attempts before lockout (>=1)
- LOCKOUT_CYCLES, 16, lockout duration in clocks
- PW_TIMEOUT, 32, clocks allowed without a pw_valid before abandoning
- CW, $clog2(CAPACITY+1), counter width (derived, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sense_entry  in  1  car present at entry gate (level)
- sense_exit  in  1  car present at exit gate (level)
- pw_valid  in  1  one-cycle strobe qualifying pw_in
- pw_in  in  PW_WIDTH  entered password
- green_light  out  1  entry granted, gate open
- red_light  out  1  entry refused (wrong password, lockout or full)
- exit_gate_open  out  1  exit gate open
- count_cars  out  CW  cars inside
- space_available  out  CW  CAPACITY - count_cars
- full  out  1  count_cars == CAPACITY
- locked  out  1  lockout in progress
- exit_error  out  1  one-cycle pulse: exit sensed with count_cars == 0
- state  out  3  current entry FSM state (debug)

## Operation
Entry FSM states: IDLE=0, WAIT_PW=1, GRANT=2, DENY=3, LOCKOUT=4, FULL_STOP=5.
- IDLE: on rising edge of sense_entry:
  - go to FULL_STOP if full;
  - otherwise go to WAIT_PW; clear tries and the timeout counter.
- WAIT_PW / DENY, evaluated in priority order:
  - sense_entry low -> IDLE.
  - pw_valid with pw_in == PASSWORD -> GRANT.
  - pw_valid with wrong code: tries+1; if tries+1 == MAX_TRIES -> LOCKOUT, else DENY. The timeout counter restarts.
  - No pw_valid for PW_TIMEOUT consecutive cycles -> IDLE.
- GRANT: on falling edge of sense_entry, count_cars+1 (the car has passed) -> IDLE.
- LOCKOUT:
  - pw_valid is ignored;
  - after LOCKOUT_CYCLES cycles -> IDLE with tries cleared;
  - sense_entry still high on return to IDLE does not re-trigger; a fresh rising edge is required.
- FULL_STOP:
  - sense_entry low -> IDLE;
  - full deasserting while sense_entry is high -> WAIT_PW.

Exit path (independent of the entry FSM):
- Rising edge of sense_exit with count_cars > 0: exit_gate_open is set and count_cars is decremented.
- exit_gate_open clears on the falling edge of sense_exit.
- Rising edge of sense_exit with count_cars == 0: exit_error pulses and the count is unchanged.

Outputs (all registered):
- green_light = (state == GRANT).
- red_light = state in {DENY, LOCKOUT, FULL_STOP}.
- locked = (state == LOCKOUT).

Arithmetic:
- count_cars never exceeds CAPACITY and never underflows.
- A simultaneous entry commit and exit decrement in the same cycle leaves count_cars unchanged.
- GRANT is only reachable when not full. An entry commit while full is impossible by construction; the implementation must still saturate.

## Timing
- Reset (asynchronous, rst_n low):
  - state=IDLE;
  - count_cars=0, space_available=CAPACITY;
  - full=0, all lights, exit_gate_open, locked and exit_error=0;
  - tries and all timers cleared.
- Reset asserted mid-transaction aborts it immediately; the count is lost by design.
- Edge detection uses registered copies of the sensors. The state changes on the clock edge after the edge is sampled, i.e. 1 cycle latency from the sampled input to state.
- Lights follow state with a further 1 cycle latency (registered decode).
- Password check: pw_valid sampled at edge N -> state updated at N+1 -> lights at N+2.
- count_cars / space_available / full update 1 cycle after the sampled falling edge (entry) or rising edge (exit).
- LOCKOUT lasts exactly LOCKOUT_CYCLES clocks in the LOCKOUT state.
- Timeout fires on the PW_TIMEOUT-th consecutive idle cycle in WAIT_PW or DENY.
- sense_entry and sense_exit high together: both paths proceed independently; neither is an error.

## Test plan
- Reset, then entry with pw 0101 -> GRANT, green_light=1; drop sense_entry -> count_cars=1, space_available=7.
- Entry with wrong codes 1111, 0000, 1010 -> DENY, DENY, LOCKOUT, locked=1 for 16 cycles; pw 0101 during lockout is ignored; after lockout -> IDLE.
- Fill to 8 cars, then new entry -> FULL_STOP, red_light=1, full=1. Exit one car while the entry car waits -> WAIT_PW; pw 0101 -> count back to 8.
- Exit at count 0 -> exit_error pulses 1 cycle, count stays 0. Entry commit and exit in the same cycle at count 3 -> count stays 3.
- WAIT_PW with no pw_valid for 32 cycles -> IDLE, no count change.
- rst_n low during GRANT -> all outputs at reset values immediately. Also rerun with CAPACITY=12, PW_WIDTH=6: full at 12, space_available tracks correctly.

Source files
------------

// File: rtl/parking_lot_controller.sv
// rtl/parking_lot_controller.sv - password-gated parking entry FSM with independent exit path and occupancy count
module parking_lot_controller #(
  parameter int                  CAPACITY       = 8,
  parameter int                  PW_WIDTH       = 4,
  parameter logic [PW_WIDTH-1:0] PASSWORD       = 4'b0101,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  LOCKOUT_CYCLES = 16,
  parameter int                  PW_TIMEOUT     = 32,
  parameter int                  CW             = $clog2(CAPACITY + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sense_entry,
  input  logic                sense_exit,
  input  logic                pw_valid,
  input  logic [PW_WIDTH-1:0] pw_in,
  output logic                green_light,
  output logic                red_light,
  output logic                exit_gate_open,
  output logic [CW-1:0]       count_cars,
  output logic [CW-1:0]       space_available,
  output logic                full,
  output logic                locked,
  output logic                exit_error,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PW   = 3'd1,
    GRANT     = 3'd2,
    DENY      = 3'd3,
    LOCKOUT   = 3'd4,
    FULL_STOP = 3'd5
  } state_t;

  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int TOW = $clog2(PW_TIMEOUT + 1);
  localparam int LKW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [CW-1:0]  CAP_V     = CW'(CAPACITY);
  localparam logic [TRW-1:0] TRIES_MAX = TRW'(MAX_TRIES);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(PW_TIMEOUT - 1);
  localparam logic [LKW-1:0] LK_LAST   = LKW'(LOCKOUT_CYCLES - 1);

  state_t             fsm, fsm_n;
  logic [TRW-1:0]     tries, tries_n;
  logic [TOW-1:0]     pw_tmr, pw_tmr_n;
  logic [LKW-1:0]     lk_tmr, lk_tmr_n;
  logic               commit;
  logic [CW-1:0]      count_n;

  logic               ent_q, ent_qq, ext_q, ext_qq;
  logic               pwv_q;
  logic [PW_WIDTH-1:0] pw_q;

  logic               ent_rise, ent_fall, ext_rise, ext_fall, exit_dec;

  assign ent_rise = ent_q & ~ent_qq;
  assign ent_fall = ~ent_q & ent_qq;
  assign ext_rise = ext_q & ~ext_qq;
  assign ext_fall = ~ext_q & ext_qq;
  assign exit_dec = ext_rise & (count_cars != '0);
  assign state    = fsm;

  // Sample sensors and the password strobe; all decisions use these registered copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q  <= 1'b0;
      ent_qq <= 1'b0;
      ext_q  <= 1'b0;
      ext_qq <= 1'b0;
      pwv_q  <= 1'b0;
      pw_q   <= '0;
    end else begin
      ent_q  <= sense_entry;
      ent_qq <= ent_q;
      ext_q  <= sense_exit;
      ext_qq <= ext_q;
      pwv_q  <= pw_valid;
      pw_q   <= pw_in;
    end
  end

  // Entry FSM state, retry count and timers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= IDLE;
      tries  <= '0;
      pw_tmr <= '0;
      lk_tmr <= '0;
    end else begin
      fsm    <= fsm_n;
      tries  <= tries_n;
      pw_tmr <= pw_tmr_n;
      lk_tmr <= lk_tmr_n;
    end
  end

  // Entry FSM next-state; commit marks the car having driven through the open gate
  always_comb begin
    fsm_n    = fsm;
    tries_n  = tries;
    pw_tmr_n = pw_tmr;
    lk_tmr_n = lk_tmr;
    commit   = 1'b0;
    case (fsm)
      IDLE: begin
        if (ent_rise) begin
          if (full) begin
            fsm_n = FULL_STOP;
          end else begin
            fsm_n    = WAIT_PW;
            tries_n  = '0;
            pw_tmr_n = '0;
          end
        end
      end
      WAIT_PW, DENY: begin
        if (!ent_q) begin
          fsm_n = IDLE;
        end else if (pwv_q && (pw_q == PASSWORD)) begin
          fsm_n = GRANT;
        end else if (pwv_q) begin
          tries_n  = tries + 1'b1;
          pw_tmr_n = '0;
          if (tries_n == TRIES_MAX) begin
            fsm_n    = LOCKOUT;
            lk_tmr_n = '0;
          end else begin
            fsm_n = DENY;
          end
        end else if (pw_tmr == TO_LAST) begin
          fsm_n = IDLE;
        end else begin
          pw_tmr_n = pw_tmr + 1'b1;
        end
      end
      GRANT: begin
        if (ent_fall) begin
          fsm_n  = IDLE;
          commit = 1'b1;
        end
      end
      LOCKOUT: begin
        if (lk_tmr == LK_LAST) begin
          fsm_n   = IDLE;
          tries_n = '0;
        end else begin
          lk_tmr_n = lk_tmr + 1'b1;
        end
      end
      FULL_STOP: begin
        if (!ent_q) begin
          fsm_n = IDLE;
        end else if (!full) begin
          fsm_n    = WAIT_PW;
          tries_n  = '0;
          pw_tmr_n = '0;
        end
      end
      default: fsm_n = IDLE;
    endcase
  end

  // Occupancy update: entry and exit in the same cycle cancel; entry saturates at capacity
  always_comb begin
    count_n = count_cars;
    if (commit && !exit_dec) begin
      if (count_cars != CAP_V) begin
        count_n = count_cars + 1'b1;
      end
    end else if (exit_dec && !commit) begin
      count_n = count_cars - 1'b1;
    end
  end

  // Occupancy and exit-gate outputs, registered from the next count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_cars      <= '0;
      space_available <= CAP_V;
      full            <= 1'b0;
      exit_gate_open  <= 1'b0;
      exit_error      <= 1'b0;
    end else begin
      count_cars      <= count_n;
      space_available <= CAP_V - count_n;
      full            <= (count_n == CAP_V);
      exit_error      <= ext_rise & (count_cars == '0);
      if (exit_dec) begin
        exit_gate_open <= 1'b1;
      end else if (ext_fall) begin
        exit_gate_open <= 1'b0;
      end
    end
  end

  // Lamp decode lags the state register by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      green_light <= 1'b0;
      red_light   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      green_light <= (fsm == GRANT);
      red_light   <= (fsm == DENY) || (fsm == LOCKOUT) || (fsm == FULL_STOP);
      locked      <= (fsm == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_parking_lot_controller.sv
// tb/tb_parking_lot_controller.sv - self-checking bench for parking_lot_controller
module tb_parking_lot_controller;

  localparam int         CAP   = 8;
  localparam logic [3:0] PASS  = 4'b0101;
  localparam int         MAXT  = 3;
  localparam int         LOCKC = 16;
  localparam int         PWTO  = 32;
  localparam logic [5:0] PASS2 = 6'b101101;

  localparam int S_IDLE = 0, S_WAIT = 1, S_GRANT = 2, S_DENY = 3, S_LOCK = 4, S_FULL = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sense_entry = 1'b0, sense_exit = 1'b0, pw_valid = 1'b0;
  logic [3:0] pw_in = '0;
  logic       green_light, red_light, exit_gate_open, full, locked, exit_error;
  logic [3:0] count_cars, space_available;
  logic [2:0] state;

  logic       sense_entry2 = 1'b0, sense_exit2 = 1'b0, pw_valid2 = 1'b0;
  logic [5:0] pw_in2 = '0;
  logic       green2, red2, exit_open2, full2, locked2, exit_error2;
  logic [3:0] count2, space2;
  logic [2:0] state2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  parking_lot_controller #(
    .CAPACITY(CAP), .PW_WIDTH(4), .PASSWORD(PASS),
    .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LOCKC), .PW_TIMEOUT(PWTO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sense_entry(sense_entry), .sense_exit(sense_exit),
    .pw_valid(pw_valid), .pw_in(pw_in), .green_light(green_light), .red_light(red_light),
    .exit_gate_open(exit_gate_open), .count_cars(count_cars), .space_available(space_available),
    .full(full), .locked(locked), .exit_error(exit_error), .state(state)
  );

  parking_lot_controller #(
    .CAPACITY(12), .PW_WIDTH(6), .PASSWORD(PASS2),
    .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LOCKC), .PW_TIMEOUT(PWTO)
  ) u_dut12 (
    .clk(clk), .rst_n(rst_n), .sense_entry(sense_entry2), .sense_exit(sense_exit2),
    .pw_valid(pw_valid2), .pw_in(pw_in2), .green_light(green2), .red_light(red2),
    .exit_gate_open(exit_open2), .count_cars(count2), .space_available(space2),
    .full(full2), .locked(locked2), .exit_error(exit_error2), .state(state2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: spec rules applied to inputs as seen at the previous two clock edges
  int   m_state = S_IDLE, m_lamp = S_IDLE, m_tries = 0, m_wait = 0, m_lock = 0, m_count = 0;
  bit   m_exit_open = 1'b0, m_exit_err = 1'b0;
  bit   a_ent = 1'b0, b_ent = 1'b0, a_ext = 1'b0, b_ext = 1'b0, a_pv = 1'b0;
  logic [3:0] a_pw = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_state = S_IDLE; m_lamp = S_IDLE; m_tries = 0; m_wait = 0; m_lock = 0; m_count = 0;
      m_exit_open = 1'b0; m_exit_err = 1'b0;
      a_ent = 1'b0; b_ent = 1'b0; a_ext = 1'b0; b_ext = 1'b0; a_pv = 1'b0; a_pw = '0;
    end else begin
      bit rise, fall, xrise, xfall, ok, bad, commit, dec;
      int nxt, nc;
      rise   = a_ent && !b_ent;
      fall   = !a_ent && b_ent;
      xrise  = a_ext && !b_ext;
      xfall  = !a_ext && b_ext;
      ok     = a_pv && (a_pw == PASS);
      bad    = a_pv && (a_pw != PASS);
      commit = 1'b0;
      nxt    = m_state;
      if (m_state == S_IDLE) begin
        if (rise) begin
          if (m_count == CAP) nxt = S_FULL;
          else begin nxt = S_WAIT; m_tries = 0; m_wait = 0; end
        end
      end else if (m_state == S_WAIT || m_state == S_DENY) begin
        if (!a_ent) nxt = S_IDLE;
        else if (ok) nxt = S_GRANT;
        else if (bad) begin
          m_tries++;
          m_wait = 0;
          if (m_tries == MAXT) begin nxt = S_LOCK; m_lock = 0; end
          else nxt = S_DENY;
        end else begin
          m_wait++;
          if (m_wait == PWTO) nxt = S_IDLE;
        end
      end else if (m_state == S_GRANT) begin
        if (fall) begin commit = 1'b1; nxt = S_IDLE; end
      end else if (m_state == S_LOCK) begin
        m_lock++;
        if (m_lock == LOCKC) begin nxt = S_IDLE; m_tries = 0; end
      end else if (m_state == S_FULL) begin
        if (!a_ent) nxt = S_IDLE;
        else if (m_count != CAP) begin nxt = S_WAIT; m_tries = 0; m_wait = 0; end
      end
      m_lamp = m_state;
      m_state = nxt;
      dec = xrise && (m_count > 0);
      m_exit_err = xrise && (m_count == 0);
      if (dec) m_exit_open = 1'b1;
      else if (xfall) m_exit_open = 1'b0;
      nc = m_count + int'(commit) - int'(dec);
      if (nc > CAP) nc = CAP;
      if (nc < 0) nc = 0;
      m_count = nc;
      b_ent = a_ent; a_ent = sense_entry;
      b_ext = a_ext; a_ext = sense_exit;
      a_pv = pw_valid; a_pw = pw_in;
    end
  end

  // Every-cycle comparison of the main DUT against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("state", 32'(state), 32'(m_state));
      check("green_light", 32'(green_light), 32'(m_lamp == S_GRANT));
      check("red_light", 32'(red_light), 32'(m_lamp == S_DENY || m_lamp == S_LOCK || m_lamp == S_FULL));
      check("locked", 32'(locked), 32'(m_lamp == S_LOCK));
      check("count_cars", 32'(count_cars), 32'(m_count));
      check("space_available", 32'(space_available), 32'(CAP - m_count));
      check("full", 32'(full), 32'(m_count == CAP));
      check("exit_gate_open", 32'(exit_gate_open), 32'(m_exit_open));
      check("exit_error", 32'(exit_error), 32'(m_exit_err));
    end
  end

  task automatic pulse(input logic [3:0] code);
    pw_in = code; pw_valid = 1'b1; tick(1);
    pw_valid = 1'b0; tick(2);
  endtask

  task automatic car_in(input logic [3:0] code);
    sense_entry = 1'b1; tick(2);
    pulse(code);
    sense_entry = 1'b0; tick(3);
  endtask

  task automatic pulse2(input logic [5:0] code);
    pw_in2 = code; pw_valid2 = 1'b1; tick(1);
    pw_valid2 = 1'b0; tick(2);
  endtask

  task automatic car_in2(input logic [5:0] code);
    sense_entry2 = 1'b1; tick(2);
    pulse2(code);
    sense_entry2 = 1'b0; tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    tick(3);
    #2 rst_n = 1'b1;
    tick(1);
    cmp_en = 1'b1;

    check("rst_state", 32'(state), 0);
    check("rst_count", 32'(count_cars), 0);
    check("rst_space", 32'(space_available), 8);
    check("rst_full", 32'(full), 0);
    check("rst_lights", 32'({green_light, red_light, locked, exit_gate_open, exit_error}), 0);
    check("rst_space12", 32'(space2), 12);

    // exit with an empty lot
    sense_exit = 1'b1; cnt = 0;
    repeat (4) begin tick(1); if (exit_error) cnt++; end
    check("exit_err_pulse_len", 32'(cnt), 1);
    check("exit_err_count", 32'(count_cars), 0);
    sense_exit = 1'b0; tick(2);

    // correct password entry
    sense_entry = 1'b1; tick(2);
    check("wait_pw_state", 32'(state), S_WAIT);
    pw_in = PASS; pw_valid = 1'b1; tick(1);
    pw_valid = 1'b0; tick(1);
    check("grant_state", 32'(state), S_GRANT);
    tick(1);
    check("grant_green", 32'(green_light), 1);
    sense_entry = 1'b0; tick(2);
    check("entry_count", 32'(count_cars), 1);
    check("entry_space", 32'(space_available), 7);
    tick(1);

    // password timeout
    sense_entry = 1'b1; tick(2);
    tick(PWTO - 1);
    check("timeout_not_yet", 32'(state), S_WAIT);
    tick(1);
    check("timeout_fired", 32'(state), S_IDLE);
    check("timeout_count", 32'(count_cars), 1);
    sense_entry = 1'b0; tick(2);

    // wrong codes into lockout; correct code during lockout ignored
    sense_entry = 1'b1; tick(2);
    pulse(4'b1111);
    check("deny1_state", 32'(state), S_DENY);
    check("deny1_red", 32'(red_light), 1);
    pulse(4'b0000);
    check("deny2_state", 32'(state), S_DENY);
    pw_in = 4'b1010; pw_valid = 1'b1; tick(1);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 5) begin pw_in = PASS; pw_valid = 1'b1; end
      else pw_valid = 1'b0;
      tick(1);
      if (locked) cnt++;
      if (i == 8) check("lockout_state", 32'(state), S_LOCK);
    end
    check("lockout_len", 32'(cnt), LOCKC);
    check("after_lockout_state", 32'(state), S_IDLE);
    check("after_lockout_count", 32'(count_cars), 1);
    sense_entry = 1'b0; tick(2);

    // build up to 3 cars, then simultaneous entry commit and exit
    car_in(PASS);
    car_in(PASS);
    check("count_three", 32'(count_cars), 3);
    sense_entry = 1'b1; tick(2);
    pulse(PASS);
    sense_entry = 1'b0; sense_exit = 1'b1; tick(2);
    check("simul_count", 32'(count_cars), 3);
    check("simul_exit_open", 32'(exit_gate_open), 1);
    tick(1);
    sense_exit = 1'b0; tick(2);
    check("simul_exit_closed", 32'(exit_gate_open), 0);

    // fill the lot
    repeat (5) car_in(PASS);
    check("fill_count", 32'(count_cars), 8);
    check("fill_full", 32'(full), 1);
    check("fill_space", 32'(space_available), 0);

    // full stop, then a car leaves and the waiting car gets in
    sense_entry = 1'b1; tick(3);
    check("full_stop_state", 32'(state), S_FULL);
    check("full_stop_red", 32'(red_light), 1);
    sense_exit = 1'b1; tick(2);
    check("full_exit_count", 32'(count_cars), 7);
    check("full_exit_full", 32'(full), 0);
    tick(1);
    check("full_to_wait", 32'(state), S_WAIT);
    sense_exit = 1'b0;
    pulse(PASS);
    check("full_grant", 32'(state), S_GRANT);
    sense_entry = 1'b0; tick(3);
    check("refill_count", 32'(count_cars), 8);
    check("refill_full", 32'(full), 1);

    // one car leaves, next car reaches GRANT, then reset hits
    sense_exit = 1'b1; tick(2);
    sense_exit = 1'b0; tick(2);
    sense_entry = 1'b1; tick(2);
    pulse(PASS);
    check("pre_reset_green", 32'(green_light), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), S_IDLE);
    check("mid_rst_green", 32'(green_light), 0);
    check("mid_rst_count", 32'(count_cars), 0);
    check("mid_rst_space", 32'(space_available), 8);
    check("mid_rst_flags", 32'({red_light, full, locked, exit_gate_open, exit_error}), 0);
    sense_entry = 1'b0;
    tick(1);
    #2 rst_n = 1'b1;
    tick(2);

    // 12-space, 6-bit password variant
    sense_entry2 = 1'b1; tick(2);
    pulse2(6'b000101);
    check("v12_deny_state", 32'(state2), S_DENY);
    check("v12_deny_red", 32'(red2), 1);
    sense_entry2 = 1'b0; tick(3);
    check("v12_idle", 32'(state2), S_IDLE);
    check("v12_count0", 32'(count2), 0);
    for (int i = 1; i <= 12; i++) begin
      car_in2(PASS2);
      if (i == 11) begin
        check("v12_space_at11", 32'(space2), 1);
        check("v12_full_at11", 32'(full2), 0);
      end
    end
    check("v12_count", 32'(count2), 12);
    check("v12_full", 32'(full2), 1);
    check("v12_space", 32'(space2), 0);
    sense_entry2 = 1'b1; tick(3);
    check("v12_full_stop", 32'(state2), S_FULL);
    sense_entry2 = 1'b0; tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
